activation_unit: RTL and testbench
==================================

Name: activation_unit

Overview:
- Datapath stage directly downstream of the activation flow controller.
- Consumes one accumulator row of MATRIX_WIDTH 32-bit words per cycle, plus the controller's time-aligned activation_function and is_signed.
- Rounds, applies the activation function and saturates each lane to one byte.
- Produces a MATRIX_WIDTH-byte row for the unified buffer, 3 cycles after input.

Parameters:
- MATRIX_WIDTH, 14, number of parallel lanes (systolic array width).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- enable  in  1  global advance; when 0 every pipeline register holds.
- acc_data  in  MATRIX_WIDTH x 32  accumulator row, one word_type per lane.
- data_valid_in  in  1  acc_data valid this cycle.
- activation_function  in  4 (activation_type)  function for this row.
- is_signed  in  1  1 = signed int8 output, 0 = unsigned uint8 output.
- act_data  out  MATRIX_WIDTH x 8  activated row, one byte_type per lane.
- data_valid_out  out  1  act_data valid.

Behaviour:
- Reset (rst=0, async): all pipeline registers, act_data and data_valid_out go to 0 immediately; function registers go to no_activation. Reset mid-row drops in-flight data; no partial row is emitted after release.
- Pipeline, advanced only when enable=1:
  - S1 registers acc_data, data_valid_in, activation_function and is_signed.
  - S2 registers the rounded value.
  - S3 registers the activated, saturated byte.
  - Latency is exactly 3 enabled cycles, with one row per cycle throughput. Function and sign travel with their row, so the function may change every cycle.
- Rounding (S1→S2):
  - xq = (x + 128) >> ACT_FRAC_SHIFT (8). The shift is arithmetic when is_signed=1 and logical when is_signed=0.
  - Held in 25 bits signed; no overflow at x = 0x7FFFFF80 or above.
- Functions (S2→S3), with sat(v, lo, hi) as clamp:
  - no_activation: signed sat(xq, -128, 127); unsigned sat(xq, 0, 255).
  - relu: signed sat(xq, 0, 127); unsigned sat(xq, 0, 255).
  - relu6: sat(xq, 0, RELU6_MAX=96), same for both signs.
  - sigmoid (hard PWL): signed sat((xq >>> 2) + 64, 0, 127); unsigned sat((xq >> 1) + 128, 0, 255).
  - Any other code: treated as no_activation.
- Output: act_data carries the low 8 bits of the saturated result. data_valid_out = S3 valid.
- act_data is updated regardless of valid. Consumers qualify with data_valid_out.
- enable=0 with data_valid_in=1: the input is not captured and no bubble is inserted. The upstream controller is frozen by the same enable.

Optional Feature:
- Macro ACT_SAT_COUNT_EN.
- Defined:
  - Adds port sat_count (out, 16 bits): count of valid lanes whose S2→S3 result was clamped.
  - Adds port sat_clear (in, 1): synchronous clear.
  - sat_count increments by the number of clamped lanes per enabled valid cycle and saturates at 0xFFFF.
  - When sat_clear and an increment coincide, the clear wins.
  - sat_count resets to 0.
- Undefined: neither port exists and no counter logic is built.

Decomposition:
- tpu_pkg gains: ACT_FRAC_SHIFT=8, RELU6_MAX=96, and byte_type/word_type if absent. It reuses activation_type with existing literals no_activation, relu, relu6, sigmoid.
- Sub-module activation_lane (one lane, combinational S2→S3 function plus saturation flag), instantiated MATRIX_WIDTH times via generate.
- Pipeline registers and valid chain live in activation_unit.

Test Plan:
- Each case holds enable=1 with data_valid_in=1 for one cycle unless stated.
- Lane0 x=0x00001280, relu, signed → act_data[0]=0x13 with data_valid_out high exactly 3 cycles later.
- Lane0 x=-1000, no_activation, signed → 0xFC; same with relu → 0x00.
- Lane0 x=0x00100000: signed no_activation → 0x7F; unsigned → 0xFF; relu6 → 0x60. With ACT_SAT_COUNT_EN, sat_count +1 per row.
- sigmoid signed: x=0 → 0x40; x=0x2800 (xq=40) → 0x4A. Unsigned x=0 → 0x80.
- Back-to-back rows alternating relu/no_activation with x=-1000:
  - Outputs alternate 0x00/0xFC, proving per-row function alignment.
  - Dropping enable for 2 cycles mid-stream holds act_data and data_valid_out, then resumes with no loss.
- Assert rst=0 asynchronously while 3 rows are in flight → act_data=0 and data_valid_out=0 immediately; no stale valid appears after rst returns to 1.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared TPU types and constants used by the activation datapath.
package tpu_pkg;

    localparam int ACT_FRAC_SHIFT = 8;
    localparam int RELU6_MAX      = 96;

    typedef logic [7:0]  byte_type;
    typedef logic [31:0] word_type;

    typedef enum logic [3:0] {
        no_activation = 4'd0,
        relu          = 4'd1,
        relu6         = 4'd2,
        sigmoid       = 4'd3
    } activation_type;

endpackage

// File: rtl/activation_lane.sv
// One lane of the activation stage: applies the selected function to a rounded
// accumulator value and clamps it to a byte, flagging when clamping occurred.
module activation_lane
    import tpu_pkg::*;
(
    input  logic [24:0] xq,
    input  logic [3:0]  func,
    input  logic        is_signed,
    output logic [7:0]  act,
    output logic        sat
);

    logic signed [25:0] v;
    logic signed [26:0] t, lo, hi, res;

    // Unsigned rows can reach 2^24 after rounding, so bit 24 is only a sign bit when signed.
    assign v = {is_signed & xq[24], xq};

    always_comb begin
        t  = {v[25], v};
        lo = is_signed ? -27'sd128 : 27'sd0;
        hi = is_signed ? 27'sd127  : 27'sd255;
        case (func)
            relu:  lo = 27'sd0;
            relu6: begin
                lo = 27'sd0;
                hi = 27'(RELU6_MAX);
            end
            sigmoid: begin
                lo = 27'sd0;
                if (is_signed) t = {{3{v[25]}}, v[25:2]} + 27'sd64;
                else           t = {2'b00, v[25:1]} + 27'sd128;
            end
            default: ;
        endcase

        res = t;
        sat = 1'b0;
        if (t < lo) begin
            res = lo;
            sat = 1'b1;
        end else if (t > hi) begin
            res = hi;
            sat = 1'b1;
        end
        act = res[7:0];
    end

endmodule

// File: rtl/activation_unit.sv
// Three-stage activation pipeline: register, round, activate+saturate per lane.
// Optional saturation counter built when ACT_SAT_COUNT_EN is defined.
module activation_unit
    import tpu_pkg::*;
#(
    parameter int MATRIX_WIDTH = 14
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [MATRIX_WIDTH-1:0][31:0] acc_data,
    input  logic                         data_valid_in,
    input  logic [3:0]                   activation_function,
    input  logic                         is_signed,
    output logic [MATRIX_WIDTH-1:0][7:0] act_data,
    output logic                         data_valid_out
`ifdef ACT_SAT_COUNT_EN
    ,
    input  logic                         sat_clear,
    output logic [15:0]                  sat_count
`endif
);

    localparam int STAGES = 3;

    logic [STAGES-1:0]              vld_pipe;
    logic [MATRIX_WIDTH-1:0][31:0]  s1_acc;
    logic [3:0]                     s1_func, s2_func;
    logic                           s1_sgn, s2_sgn;
    logic [MATRIX_WIDTH-1:0][24:0]  s2_xq, xq_nxt;
    logic [MATRIX_WIDTH-1:0][7:0]   act_nxt;
    logic [MATRIX_WIDTH-1:0]        lane_sat;

    for (genvar g = 0; g < MATRIX_WIDTH; g++) begin : g_lane
        logic [32:0] rnd;
        // Sign-extend only for signed rows; slicing the 33-bit sum then gives
        // arithmetic or logical shift as required.
        assign rnd       = {s1_sgn & s1_acc[g][31], s1_acc[g]} + (33'd1 << (ACT_FRAC_SHIFT - 1));
        assign xq_nxt[g] = 25'(rnd >> ACT_FRAC_SHIFT);

        activation_lane u_lane (
            .xq        (s2_xq[g]),
            .func      (s2_func),
            .is_signed (s2_sgn),
            .act       (act_nxt[g]),
            .sat       (lane_sat[g])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe <= '0;
            s1_acc   <= '0;
            s1_func  <= no_activation;
            s1_sgn   <= 1'b0;
            s2_xq    <= '0;
            s2_func  <= no_activation;
            s2_sgn   <= 1'b0;
            act_data <= '0;
        end else if (enable) begin
            vld_pipe <= {vld_pipe[STAGES-2:0], data_valid_in};
            s1_acc   <= acc_data;
            s1_func  <= activation_function;
            s1_sgn   <= is_signed;
            s2_xq    <= xq_nxt;
            s2_func  <= s1_func;
            s2_sgn   <= s1_sgn;
            act_data <= act_nxt;
        end
    end

    assign data_valid_out = vld_pipe[STAGES-1];

`ifdef ACT_SAT_COUNT_EN
    logic [15:0] sat_inc;
    logic [16:0] sat_sum;

    always_comb begin
        sat_inc = '0;
        for (int i = 0; i < MATRIX_WIDTH; i++) sat_inc = sat_inc + 16'(lane_sat[i]);
        sat_sum = {1'b0, sat_count} + {1'b0, sat_inc};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                        sat_count <= '0;
        else if (sat_clear)              sat_count <= '0;
        else if (enable && vld_pipe[1])  sat_count <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end
`else
    logic unused_sat;
    assign unused_sat = ^lane_sat;
`endif

endmodule

// File: tb/tb_activation_unit.sv
// Directed-vector bench for activation_unit; also checks the saturation
// counter when built with ACT_SAT_COUNT_EN.
module tb_activation_unit;
    import tpu_pkg::*;

    localparam int MW = 14;
    localparam logic [31:0] NEG1000 = 32'hFFFFFC18;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 enable = 1'b0;
    logic                 data_valid_in = 1'b0;
    logic                 is_signed = 1'b0;
    logic [3:0]           activation_function = 4'd0;
    logic [MW-1:0][31:0]  acc_data = '0;
    logic [MW-1:0][7:0]   act_data;
    logic                 data_valid_out;
`ifdef ACT_SAT_COUNT_EN
    logic                 sat_clear = 1'b0;
    logic [15:0]          sat_count;
    int                   exp_sat = 0;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0]         got_q[$];
    logic [7:0]         prev_d;
    logic               prev_v;
    logic [MW-1:0][7:0] exp_row;
    int                 r;

    always #5 clk = ~clk;

    activation_unit #(.MATRIX_WIDTH(MW)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .enable              (enable),
        .acc_data            (acc_data),
        .data_valid_in       (data_valid_in),
        .activation_function (activation_function),
        .is_signed           (is_signed),
        .act_data            (act_data),
        .data_valid_out      (data_valid_out)
`ifdef ACT_SAT_COUNT_EN
        ,
        .sat_clear           (sat_clear),
        .sat_count           (sat_count)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One row on lane 0 (other lanes zero); checks valid timing and result.
    task automatic run_one(input string tag, input logic [31:0] x, input logic [3:0] func,
                           input logic sgn, input logic [7:0] exp, input int nsat);
        @(negedge clk);
        acc_data            = '0;
        acc_data[0]         = x;
        activation_function = func;
        is_signed           = sgn;
        data_valid_in       = 1'b1;
        @(negedge clk);
        data_valid_in = 1'b0;
        @(negedge clk);
        chk({tag, "_vld_early"}, data_valid_out, 1'b0);
        @(negedge clk);
        chk({tag, "_vld"}, data_valid_out, 1'b1);
        chk({tag, "_dat"}, act_data[0], exp);
`ifdef ACT_SAT_COUNT_EN
        exp_sat += nsat;
        chk({tag, "_sat"}, sat_count, exp_sat);
`else
        if (nsat < 0) $display("bad nsat");
`endif
    endtask

    initial begin
        #12;
        chk("reset_vld", data_valid_out, 1'b0);
        chk("reset_dat", act_data, '0);
`ifdef ACT_SAT_COUNT_EN
        chk("reset_sat", sat_count, 16'd0);
`endif
        @(negedge clk);
        rst    = 1'b1;
        enable = 1'b1;

        run_one("relu_pos",     32'h00001280, relu,          1'b1, 8'h13, 0);
        run_one("noact_neg",    NEG1000,      no_activation, 1'b1, 8'hFC, 0);
        run_one("relu_neg",     NEG1000,      relu,          1'b1, 8'h00, 1);
        run_one("noact_big_s",  32'h00100000, no_activation, 1'b1, 8'h7F, 1);
        run_one("noact_big_u",  32'h00100000, no_activation, 1'b0, 8'hFF, 1);
        run_one("relu6_big",    32'h00100000, relu6,         1'b1, 8'h60, 1);
        run_one("sig_s_zero",   32'h00000000, sigmoid,       1'b1, 8'h40, 0);
        run_one("sig_s_40",     32'h00002800, sigmoid,       1'b1, 8'h4A, 0);
        run_one("sig_u_zero",   32'h00000000, sigmoid,       1'b0, 8'h80, 0);
        run_one("round_up",     32'h00000180, no_activation, 1'b1, 8'h02, 0);
        run_one("round_dn",     32'h0000017F, no_activation, 1'b1, 8'h01, 0);
        run_one("top_s",        32'h7FFFFF80, no_activation, 1'b1, 8'h7F, 1);
        run_one("top_u",        32'hFFFFFFFF, no_activation, 1'b0, 8'hFF, 1);
        run_one("relu_u_msb",   32'h80000000, relu,          1'b0, 8'hFF, 1);
        run_one("code_other",   NEG1000,      4'd9,          1'b1, 8'hFC, 0);

        // Full row: lane i holds i<<8, so every lane should read back i.
        @(negedge clk);
        for (int i = 0; i < MW; i++) begin
            acc_data[i] = 32'(i) << 8;
            exp_row[i]  = 8'(i);
        end
        activation_function = no_activation;
        is_signed           = 1'b1;
        data_valid_in       = 1'b1;
        @(negedge clk);
        data_valid_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("row_vld", data_valid_out, 1'b1);
        chk("row_dat", act_data, exp_row);

        // Back-to-back alternating functions with a 2-cycle enable drop.
        @(negedge clk);
        prev_d = act_data[0];
        prev_v = data_valid_out;
        r = 0;
        for (int c = 0; c < 14; c++) begin
            enable = !(c == 3 || c == 4);
            if (r < 6) begin
                acc_data            = '0;
                acc_data[0]         = NEG1000;
                activation_function = (r % 2 == 0) ? relu : no_activation;
                is_signed           = 1'b1;
                data_valid_in       = 1'b1;
            end else begin
                data_valid_in = 1'b0;
            end
            if (enable && r < 6) r++;
            @(negedge clk);
            if (!enable) begin
                chk("hold_dat", act_data[0], prev_d);
                chk("hold_vld", data_valid_out, prev_v);
            end else if (data_valid_out) begin
                got_q.push_back(act_data[0]);
            end
            prev_d = act_data[0];
            prev_v = data_valid_out;
        end
        enable = 1'b1;
        chk("b2b_count", got_q.size(), 6);
        for (int i = 0; i < 6 && i < got_q.size(); i++)
            chk("b2b_seq", got_q[i], (i % 2 == 0) ? 8'h00 : 8'hFC);
`ifdef ACT_SAT_COUNT_EN
        exp_sat += 3;
        chk("b2b_sat", sat_count, exp_sat);

        // Clear coincides with an increment; clear must win.
        run_one("pre_clear", 32'h00100000, no_activation, 1'b1, 8'h7F, 1);
        @(negedge clk);
        acc_data[0] = 32'h00100000;
        data_valid_in = 1'b1;
        @(negedge clk);
        data_valid_in = 1'b0;
        @(negedge clk);
        sat_clear = 1'b1;
        @(negedge clk);
        sat_clear = 1'b0;
        exp_sat = 0;
        chk("sat_clear_wins", sat_count, exp_sat);
`endif

        // Async reset with three rows in flight.
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            acc_data            = '0;
            acc_data[0]         = 32'h00001280;
            activation_function = relu;
            is_signed           = 1'b1;
            data_valid_in       = 1'b1;
            @(negedge clk);
        end
        data_valid_in = 1'b0;
        chk("inflight_vld", data_valid_out, 1'b1);
        chk("inflight_dat", act_data[0], 8'h13);
        #1 rst = 1'b0;
        #1;
        chk("async_rst_vld", data_valid_out, 1'b0);
        chk("async_rst_dat", act_data, '0);
`ifdef ACT_SAT_COUNT_EN
        chk("async_rst_sat", sat_count, 16'd0);
`endif
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_vld", data_valid_out, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
